// File: rtl/spi_tx_frame_ctrl.sv
// Frame controller for an SPI shift-register stage: buffers parallel words in a
// small FIFO and sequences a load cycle, DATA_WIDTH shift cycles and an inter-frame gap.

`ifndef SPI_DATA_WIDTH
`define SPI_DATA_WIDTH 8
`endif

module spi_tx_frame_ctrl #(
  parameter int DATA_WIDTH = `SPI_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          spi_clk,
  input  logic                          spi_rst,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          spi_cs,
  output logic [DATA_WIDTH-1:0]         spi_data_in,
  output logic                          spi_bit_valid,
  output logic                          frame_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST   = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] BIT_ONE    = CW'(1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  shift_last;
  logic                  gap_last;

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready depends only on the registered level, so a full FIFO never passes through.
  always_comb begin
    fifo_empty = (level == '0);
    tx_ready   = (level != LEVEL_FULL);
    push       = tx_valid && tx_ready;
    shift_last = (state == SHIFT) && (bit_cnt == '0);
    gap_last   = (state == GAP) && (gap_cnt == '0);
    pop        = !fifo_empty &&
                 ((state == IDLE) || (shift_last && (GAP_CYCLES == 0)) || gap_last);
  end

  assign busy       = !fifo_empty || (state != IDLE);
  assign fifo_level = level;
  assign fsm_state  = state;

  always_ff @(posedge spi_clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      spi_cs        <= 1'b1;
      spi_data_in   <= '0;
      spi_bit_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state       <= LOAD;
            spi_cs      <= 1'b0;
            spi_data_in <= mem[rd_ptr];
          end
        end
        LOAD: begin
          state         <= SHIFT;
          bit_cnt       <= BIT_LAST;
          spi_cs        <= 1'b1;
          spi_bit_valid <= 1'b1;
          frame_done    <= 1'b0;
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            spi_bit_valid <= 1'b0;
            frame_done    <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LAST;
            end else if (pop) begin
              state       <= LOAD;
              spi_cs      <= 1'b0;
              spi_data_in <= mem[rd_ptr];
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt    <= bit_cnt - 1'b1;
            frame_done <= (bit_cnt == BIT_ONE);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (pop) begin
              state       <= LOAD;
              spi_cs      <= 1'b0;
              spi_data_in <= mem[rd_ptr];
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          spi_cs        <= 1'b1;
          spi_bit_valid <= 1'b0;
          frame_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_tx_frame_ctrl.md
# spi_tx_frame_ctrl

Upstream frame controller for the SPI shift-register stage. Accepts parallel words on a valid/ready handshake and buffers them in a small FIFO. For each word, it drives the shift register's chip-select/load input and parallel data input through one load cycle and DATA_WIDTH shift cycles. It also flags the cycles in which the downstream register's MSB carries a valid serial bit, and inserts a programmable inter-frame gap.

## Interface
- DATA_WIDTH, default `SPI_DATA_WIDTH (8): word width; must equal the downstream shift register width; minimum 2.
- FIFO_DEPTH, default 4: word buffer entries; power of two, minimum 2.
- GAP_CYCLES, default 2: idle cycles with spi_cs=1 between consecutive frames; 0 is legal.

Ports:
- spi_clk  in  1  sole clock; all logic on rising edge.
- spi_rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_WIDTH  word to transmit, MSB sent first.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  FIFO not full; a word is accepted on an edge where tx_valid && tx_ready.
- spi_cs  out  1  downstream load control: 0 = load spi_data_in, 1 = shift.
- spi_data_in  out  DATA_WIDTH  word presented to the downstream register.
- spi_bit_valid  out  1  downstream MSB is a valid data bit this cycle.
- frame_done  out  1  high during the last valid bit of a frame.
- busy  out  1  FIFO non-empty or state != IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE: spi_cs=1. If the FIFO is non-empty, the next edge enters LOAD, pops the FIFO head and registers it into spi_data_in.
  - LOAD: lasts exactly 1 cycle. spi_cs=0 and spi_data_in is stable; the downstream register captures the word at the end of the cycle. The next state is SHIFT, with bit_cnt=DATA_WIDTH-1.
  - SHIFT: lasts DATA_WIDTH cycles. spi_cs=1 and spi_bit_valid=1. bit_cnt decrements each edge, so the downstream MSB carries tx_data bit bit_cnt. frame_done=1 when bit_cnt==0.
  - Exit from SHIFT at bit_cnt==0:
    - to GAP if GAP_CYCLES>0;
    - otherwise to LOAD (with pop) if the FIFO is non-empty;
    - otherwise to IDLE.
  - GAP: lasts GAP_CYCLES cycles with spi_cs=1 and spi_bit_valid=0, then goes to LOAD (with pop) if the FIFO is non-empty, otherwise to IDLE.
- spi_data_in changes only on an edge entering LOAD and holds its value until the next LOAD.
- FIFO rules:
  - Push when tx_valid && tx_ready.
  - Pop only on an edge entering LOAD.
  - A simultaneous push and pop leaves the level unchanged.
  - tx_ready = (fifo_level != FIFO_DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Words are transmitted in acceptance order.
- tx_data/tx_valid while tx_ready=0 are ignored; no data is lost or duplicated.
- Reset values: spi_cs=1, spi_data_in=0, spi_bit_valid=0, frame_done=0, busy=0, fifo_level=0, tx_ready=1, state IDLE.
- Reset mid-frame:
  - The frame is abandoned and the FIFO is emptied.
  - spi_cs=1 and spi_bit_valid=0 from the first cycle after the reset edge.
  - The downstream register keeps shifting harmlessly.

## Timing
- All outputs are registers or decodes of registered state only; there are no combinational paths from tx_* to outputs other than none.
- Latency into an empty, idle block:
  - Word accepted at edge 0; LOAD cycle runs between edges 1 and 2.
  - First spi_bit_valid cycle follows edge 2.
  - frame_done occurs in the cycle after edge 1+DATA_WIDTH.
- Frame period with back-to-back words is 1+DATA_WIDTH+GAP_CYCLES cycles. With GAP_CYCLES=0 it is DATA_WIDTH+1 cycles, and the LOAD cycle immediately follows the frame_done cycle.
- A push arriving during GAP or SHIFT is eligible for the very next transition out of that state.
- spi_bit_valid is never high while spi_cs=0.

## Test plan
- Single word, defaults: push 8'hA5 at edge 0. Required response:
  - spi_cs=0 for exactly one cycle (edges 1–2), with spi_data_in=8'hA5;
  - spi_bit_valid high for 8 cycles, serial bits 1,0,1,0,0,1,0,1;
  - frame_done in the 8th bit cycle;
  - busy falls after the frame.
- Back-to-back: push 8'h01, 8'h80, 8'hFF on consecutive edges. Required response:
  - three frames in order;
  - cs low edges spaced exactly 11 cycles apart (1+8+2);
  - GAP_CYCLES=0 build gives 9-cycle spacing.
- FIFO full: hold tx_valid for 6 words during one frame. Required response:
  - tx_ready drops at fifo_level=4;
  - the stalled word is accepted only after a pop;
  - all 6 words are transmitted in order with none duplicated.
- Simultaneous push/pop: push on the edge entering LOAD with fifo_level=2 -> level stays 2 and data order is preserved.
- Reset mid-SHIFT: assert spi_rst at bit 3 with 2 words queued. Required response:
  - next cycle spi_cs=1, spi_bit_valid=0, fifo_level=0, spi_data_in=0;
  - a new push after reset transmits cleanly with standard latency.
